// File: rtl/shift_seq_pkg.sv
// rtl/shift_seq_pkg.sv - shared state encoding and default widths for the serial shift sequencer
package shift_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DW_DEFAULT    = 8;
    localparam int DIV_W_DEFAULT = 16;

endpackage

// File: rtl/bit_timer.sv
// rtl/bit_timer.sv - bit-period divider; pulses tick on the last cycle of each bit while running
module bit_timer #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] div_lat;
    logic [DIV_W-1:0] cnt;

    // The period is captured at load so later div changes cannot disturb a transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_lat <= '0;
            cnt     <= '0;
        end else if (load) begin
            div_lat <= div;
            cnt     <= div;
        end else if (run) begin
            if (cnt == '0) begin
                cnt <= div_lat;
            end else begin
                cnt <= cnt - DIV_W'(1);
            end
        end
    end

    assign tick = rst_n && run && (cnt == '0);

endmodule

// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - MSB-first serial shifter: sends s_data on sdo while capturing sdi into rx_data
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int DIV_W = DIV_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DW-1:0]    s_data,
    input  logic [DIV_W-1:0] div,
    input  logic             abort,
    input  logic             sdi,
    output logic             sdo,
    output logic             frame,
    output logic             bit_tick,
    output logic             done,
    output logic [DW-1:0]    rx_data
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DW - 1);

    state_t        state;
    logic [DW-1:0] q;
    logic [DW-1:0] q_next;
    logic [CW-1:0] bit_cnt;
    logic          shifting;
    logic          accept;
    logic          tick;

    assign shifting = (state == SHIFT);
    assign s_ready  = rst_n && (state == IDLE);
    assign accept   = s_valid && s_ready;
    assign q_next   = {q[DW-2:0], sdi};

    bit_timer #(
        .DIV_W(DIV_W)
    ) u_bit_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .load (accept),
        .run  (shifting),
        .div  (div),
        .tick (tick)
    );

    // Abort is checked before the tick so it wins over a coincident final bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            q       <= '0;
            bit_cnt <= '0;
            rx_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        q       <= s_data;
                        bit_cnt <= LAST_BIT;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (tick) begin
                        q <= q_next;
                        if (bit_cnt == '0) begin
                            rx_data <= q_next;
                            state   <= DONE;
                        end else begin
                            bit_cnt <= bit_cnt - CW'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign frame    = rst_n && shifting;
    assign sdo      = frame && q[DW-1];
    assign bit_tick = tick;
    assign done     = rst_n && (state == DONE);

endmodule
